tmds_decoder: RTL and testbench

Per-channel TMDS receive decoder: converts one 10-bit TMDS symbol per pixel clock back into 8-bit pixel data or a 2-bit control code. It is the receive-side inverse of the transmit encoder chain, and recomputes the transmit XOR/XNOR decision to flag illegal data symbols. Word alignment is recovered by hunting for control-token runs and pulsing a bit-slip request to the upstream deserializer. It sits between the 1:10 deserializer and the channel-deskew / video timing logic.

---
 rtl/tmds_pkg.sv | 14 +
 rtl/tmds_decoder_if.sv | 20 ++
 rtl/tmds_symbol_decode.sv | 29 ++
 rtl/tmds_decoder.sv | 150 +++++++++++++++
 tb/tb_tmds_decoder.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/tmds_pkg.sv
// tmds_pkg: shared TMDS definitions - control tokens, receive FSM states, XOR/XNOR decision
//   TOK_00..TOK_11 : the four 10-bit control tokens, suffix is {C1,C0}
//   state_e        : decoder alignment FSM states
//   tmds_use_xnor  : transmit-side XNOR decision for a data byte (also used by the encoder)
package tmds_pkg;
    localparam logic [9:0] TOK_00 = 10'b1101010100;
    localparam logic [9:0] TOK_01 = 10'b0010101011;
    localparam logic [9:0] TOK_10 = 10'b0101010100;
    localparam logic [9:0] TOK_11 = 10'b1010101011;
    typedef enum logic [1:0] {SEARCH, SLIP, LOCKED} state_e;
    function automatic logic tmds_use_xnor(input logic [7:0] b);
        return ($countones(b) > 4) || ($countones(b) == 4 && !b[0]);
    endfunction
endpackage

// File: rtl/tmds_decoder_if.sv
// tmds_decoder_if: deserializer-side symbol input and decoded outputs of one TMDS channel
//   sym_in  : raw 10-bit word from the deserializer
//   bitslip : one-cycle slip request back to the deserializer
//   aligned : word alignment locked
//   de      : data enable for the decoded byte
//   data    : decoded pixel byte
//   ctrl    : decoded control code {C1,C0}
//   err     : invalid data symbol seen while locked
//   master  : symbol source / output consumer side; slave: the decoder
interface tmds_decoder_if;
    logic [9:0] sym_in;
    logic       bitslip;
    logic       aligned;
    logic       de;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       err;
    modport master (output sym_in, input bitslip, aligned, de, data, ctrl, err);
    modport slave  (input sym_in, output bitslip, aligned, de, data, ctrl, err);
endinterface

// File: rtl/tmds_symbol_decode.sv
// tmds_symbol_decode: combinational classification and decode of one TMDS symbol
//   sym     : raw symbol, bit 9 = invert flag, bit 8 = XOR flag (1 = XOR)
//   is_ctrl : symbol is one of the four control tokens
//   ctrl    : control code {C1,C0} (00 when not a token)
//   q       : decoded data byte
//   invalid : data symbol whose XOR flag contradicts the transmit decision
//             (port exists only with TMDS_DEC_ERRCHK_EN defined)
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [9:0] sym,
    output logic       is_ctrl,
    output logic [1:0] ctrl,
    output logic [7:0] q
`ifdef TMDS_DEC_ERRCHK_EN
    ,
    output logic       invalid
`endif
);
    logic [7:0] d;
    assign d       = sym[9] ? ~sym[7:0] : sym[7:0];
    // XNOR is XOR with an extra inversion, applied when the XOR flag is clear
    assign q       = {d[7:1] ^ d[6:0] ^ {7{~sym[8]}}, d[0]};
    assign is_ctrl = sym inside {TOK_00, TOK_01, TOK_10, TOK_11};
    assign ctrl    = sym == TOK_01 ? 2'b01 : sym == TOK_10 ? 2'b10 : sym == TOK_11 ? 2'b11 : 2'b00;
`ifdef TMDS_DEC_ERRCHK_EN
    assign invalid = !is_ctrl && (tmds_use_xnor(q) == sym[8]);
`endif
endmodule

// File: rtl/tmds_decoder.sv
// tmds_decoder: per-channel TMDS receive decoder with control-token word alignment
//   clk : pixel clock
//   rst : asynchronous active-high reset
//   bus : tmds_decoder_if.slave - sym_in in; bitslip, aligned, de, data, ctrl, err out
// Define TMDS_DEC_ERRCHK_EN to include the validity check, error counter, err and lock loss;
// without it err is tied low and LOCKED is left only by reset.
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN   = 8,
    parameter int SEARCH_LEN = 64,
    parameter int SLIP_WAIT  = 4
`ifdef TMDS_DEC_ERRCHK_EN
    ,
    parameter int ERR_LIMIT  = 4
`endif
) (
    input logic           clk,
    input logic           rst,
    tmds_decoder_if.slave bus
);
    localparam int RW = $clog2(CTRL_RUN) + 1;
    localparam int TW = $clog2(SEARCH_LEN) + 1;
    localparam int WW = $clog2(SLIP_WAIT) + 1;
    localparam logic [RW-1:0] RUN_MAX   = RW'(CTRL_RUN);
    localparam logic [TW-1:0] TIMER_MAX = TW'(SEARCH_LEN);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(SLIP_WAIT);
    state_e        state_q, state_d;
    logic [9:0]    sym_q, sym_d;
    logic [RW-1:0] run_q, run_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          bitslip_q, bitslip_d;
    logic          de_q, de_d;
    logic [7:0]    data_q, data_d;
    logic [1:0]    ctrl_q, ctrl_d;
    logic          dec_ctrl;
    logic [1:0]    dec_code;
    logic [7:0]    dec_q;
`ifdef TMDS_DEC_ERRCHK_EN
    localparam int EW = $clog2(ERR_LIMIT) + 1;
    localparam logic [EW-1:0] ERR_MAX = EW'(ERR_LIMIT);
    logic [EW-1:0] err_cnt_q, err_cnt_d;
    logic          err_q, err_d;
    logic          dec_invalid;
`endif
    tmds_symbol_decode u_dec (
        .sym     (sym_q),
        .is_ctrl (dec_ctrl),
        .ctrl    (dec_code),
        .q       (dec_q)
`ifdef TMDS_DEC_ERRCHK_EN
        ,
        .invalid (dec_invalid)
`endif
    );
    // The FSM looks at the stage-1 symbol, so aligned changes together with that symbol's decode.
    always_comb begin
        sym_d     = bus.sym_in;
        state_d   = state_q;
        run_d     = dec_ctrl ? (run_q == RUN_MAX ? run_q : run_q + 1'b1) : '0;
        timer_d   = '0;
        wait_d    = '0;
        bitslip_d = 1'b0;
        de_d      = !dec_ctrl && state_q == LOCKED;
        data_d    = dec_ctrl ? data_q : dec_q;
        ctrl_d    = dec_ctrl ? dec_code : ctrl_q;
`ifdef TMDS_DEC_ERRCHK_EN
        err_cnt_d = err_cnt_q;
        err_d     = 1'b0;
`endif
        case (state_q)
            SEARCH: begin
                timer_d = timer_q == TIMER_MAX ? timer_q : timer_q + 1'b1;
                if (run_d == RUN_MAX) begin
                    state_d = LOCKED;
`ifdef TMDS_DEC_ERRCHK_EN
                    err_cnt_d = '0;
`endif
                end else if (timer_q == TIMER_MAX - 1'b1) begin
                    state_d   = SLIP;
                    bitslip_d = 1'b1;
                end
            end
            SLIP: begin
                run_d  = '0;
                wait_d = wait_q == WAIT_MAX ? wait_q : wait_q + 1'b1;
                if (wait_q == WAIT_MAX - 1'b1)
                    state_d = SEARCH;
            end
            LOCKED: begin
`ifdef TMDS_DEC_ERRCHK_EN
                if (run_d == RUN_MAX)
                    err_cnt_d = '0;
                else if (dec_invalid) begin
                    err_cnt_d = err_cnt_q == ERR_MAX ? err_cnt_q : err_cnt_q + 1'b1;
                    err_d     = 1'b1;
                end
                if (err_cnt_d == ERR_MAX) begin
                    state_d   = SEARCH;
                    err_cnt_d = '0;
                    run_d     = '0;
                end
`endif
            end
            default: state_d = SEARCH;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= SEARCH;
            sym_q     <= '0;
            run_q     <= '0;
            timer_q   <= '0;
            wait_q    <= '0;
            bitslip_q <= 1'b0;
            de_q      <= 1'b0;
            data_q    <= '0;
            ctrl_q    <= '0;
`ifdef TMDS_DEC_ERRCHK_EN
            err_cnt_q <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sym_q     <= sym_d;
            run_q     <= run_d;
            timer_q   <= timer_d;
            wait_q    <= wait_d;
            bitslip_q <= bitslip_d;
            de_q      <= de_d;
            data_q    <= data_d;
            ctrl_q    <= ctrl_d;
`ifdef TMDS_DEC_ERRCHK_EN
            err_cnt_q <= err_cnt_d;
            err_q     <= err_d;
`endif
        end
    end
    assign bus.bitslip = bitslip_q;
    assign bus.aligned = state_q == LOCKED;
    assign bus.de      = de_q;
    assign bus.data    = data_q;
    assign bus.ctrl    = ctrl_q;
`ifdef TMDS_DEC_ERRCHK_EN
    assign bus.err     = err_q;
`else
    assign bus.err     = 1'b0;
`endif
endmodule

// File: tb/tb_tmds_decoder.sv
// tb_tmds_decoder: directed self-checking bench for tmds_decoder
module tb_tmds_decoder;
    localparam logic [9:0] TOK00 = 10'b1101010100;
    localparam logic [9:0] TOK01 = 10'b0010101011;
    // XNOR-flagged symbol decoding to 8'h01, a byte the transmitter would send with XOR
    localparam logic [9:0] INV   = 10'h055;
    localparam logic [9:0] NOISE = 10'b1111100000;
`ifdef TMDS_DEC_ERRCHK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [9:0] sweep [512];
    int   pulses, p1, p2, p3;
    bit   saw_aligned;
    tmds_decoder_if bus ();
    tmds_decoder dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask
    task automatic drive(input logic [9:0] s);
        bus.sym_in = s;
        @(posedge clk);
        #1;
    endtask
    function automatic logic [8:0] enc_qm(input logic [7:0] b);
        int n = 0;
        logic xn;
        logic [8:0] qm;
        for (int k = 0; k < 8; k++) n += int'(b[k]);
        xn = (n > 4) || (n == 4 && b[0] == 1'b0);
        qm[0] = b[0];
        for (int k = 1; k < 8; k++) qm[k] = xn ? ~(qm[k-1] ^ b[k]) : (qm[k-1] ^ b[k]);
        qm[8] = ~xn;
        return qm;
    endfunction
    initial begin
        for (int b = 0; b < 256; b++) begin
            logic [8:0] qm;
            qm = enc_qm(8'(b));
            sweep[2*b]   = {1'b0, qm};
            sweep[2*b+1] = {1'b1, qm[8], ~qm[7:0]};
        end
        bus.sym_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_aligned", bus.aligned, 0);
        check("rst_bitslip", bus.bitslip, 0);
        check("rst_de", bus.de, 0);
        check("rst_data", bus.data, 0);
        check("rst_ctrl", bus.ctrl, 0);
        check("rst_err", bus.err, 0);
        rst = 1'b0;
        repeat (8) drive(TOK00);
        check("prelock_aligned", bus.aligned, 0);
        drive(TOK00);
        check("lock_aligned", bus.aligned, 1);
        check("lock_ctrl", bus.ctrl, 2'b00);
        check("lock_de", bus.de, 0);
        for (int i = 0; i < 513; i++) begin
            drive(i < 512 ? sweep[i] : TOK01);
            if (i > 0) begin
                check("sweep_data", bus.data, 32'((i - 1) / 2));
                check("sweep_de", bus.de, 1);
                check("sweep_err", bus.err, 0);
            end
        end
        check("sweep_ctrl_hold", bus.ctrl, 2'b00);
        drive(TOK01);
        check("tok_ctrl", bus.ctrl, 2'b01);
        check("tok_de", bus.de, 0);
        check("tok_data_hold", bus.data, 8'hFF);
        drive(INV);
        drive(TOK01);
        check("inv_err", bus.err, ERRCHK);
        check("inv_de", bus.de, 1);
        check("inv_data", bus.data, 8'h01);
        drive(TOK01);
        check("inv_err_pulse", bus.err, 0);
        repeat (3) drive(INV);
        drive(TOK01);
        check("limit_err", bus.err, ERRCHK);
        check("limit_aligned", bus.aligned, !ERRCHK);
        repeat (9) drive(TOK00);
        check("relock_aligned", bus.aligned, 1);
        repeat (3) drive(INV);
        repeat (5) drive(TOK01);
        check("blank_ctrl", bus.ctrl, 2'b01);
        check("blank_de", bus.de, 0);
        repeat (3) drive(TOK01);
        repeat (3) drive(INV);
        drive(TOK01);
        drive(TOK01);
        check("errclr_aligned", bus.aligned, 1);
        drive(sweep[330]);
        drive(sweep[330]);
        check("pre_rst_de", bus.de, 1);
        check("pre_rst_data", bus.data, 8'hA5);
        rst = 1'b1;
        #1;
        check("midrst_aligned", bus.aligned, 0);
        check("midrst_de", bus.de, 0);
        check("midrst_data", bus.data, 0);
        check("midrst_ctrl", bus.ctrl, 0);
        check("midrst_err", bus.err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) drive(TOK00);
        check("fresh_prelock", bus.aligned, 0);
        drive(TOK00);
        check("fresh_lock", bus.aligned, 1);
        rst = 1'b1;
        bus.sym_in = NOISE;
        @(posedge clk);
        #1;
        rst = 1'b0;
        pulses = 0;
        p1 = 0;
        p2 = 0;
        p3 = 0;
        saw_aligned = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (bus.bitslip) begin
                pulses++;
                if (pulses == 1) p1 = n;
                if (pulses == 2) p2 = n;
                if (pulses == 3) p3 = n;
            end
            if (bus.aligned) saw_aligned = 1'b1;
        end
        check("slip_first", p1, 64);
        check("slip_second", p2, 132);
        check("slip_third", p3, 200);
        check("slip_count", pulses, 3);
        check("slip_no_align", saw_aligned, 0);
        check("slip_high", bus.bitslip, 1);
        rst = 1'b1;
        #1;
        check("slip_rst_bitslip", bus.bitslip, 0);
        check("slip_rst_aligned", bus.aligned, 0);
        check("slip_rst_de", bus.de, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
